// File: rtl/decode_issue_ctrl.sv
// Scoreboard issue controller for decode: per-register pending-write counters, RAW/saturation stall, HALT drain.
// Optional macro DECODE_ISSUE_BYPASS_EN: a source whose last pending write retires this cycle is not a hazard.
module decode_issue_ctrl #(
    parameter int CNT_W    = 2,
    parameter int NUM_REGS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [2:0]          id_rs,
    input  logic                id_rs_used,
    input  logic [2:0]          id_rt,
    input  logic                id_rt_used,
    input  logic [2:0]          id_rd,
    input  logic                id_rd_write,
    input  logic                id_halt,
    input  logic                flush,
    input  logic                wb_valid,
    input  logic [2:0]          wb_rd,
    output logic                issue,
    output logic                stall,
    output logic                halted,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                err
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt      [NUM_REGS];
    logic [CNT_W-1:0]   cnt_next [NUM_REGS];
    logic [NUM_REGS-1:0] busy_next;
    logic               rs_bypass;
    logic               rt_bypass;
    logic               raw;
    logic               sat;
    logic               all_zero_next;
    logic               underflow;
    logic               inc;
    logic               dec;

    // A retiring write can only cover the hazard if it is the last one outstanding.
`ifdef DECODE_ISSUE_BYPASS_EN
    assign rs_bypass = wb_valid && (wb_rd == id_rs) && (cnt[id_rs] == CNT_W'(1));
    assign rt_bypass = wb_valid && (wb_rd == id_rt) && (cnt[id_rt] == CNT_W'(1));
`else
    assign rs_bypass = 1'b0;
    assign rt_bypass = 1'b0;
`endif

    assign raw = (id_rs_used && (cnt[id_rs] != '0) && !rs_bypass)
               | (id_rt_used && (cnt[id_rt] != '0) && !rt_bypass);
    assign sat = id_rd_write && (cnt[id_rd] == '1);

    assign issue     = (state == RUN) && id_valid && !flush && !raw && !sat;
    assign stall     = id_valid && !flush && !issue;
    assign underflow = wb_valid && (cnt[wb_rd] == '0);

    always_comb begin
        all_zero_next = 1'b1;
        busy_next     = '0;
        inc           = 1'b0;
        dec           = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_next[r] = cnt[r];
            inc = issue && id_rd_write && (id_rd == 3'(r));
            dec = wb_valid && (wb_rd == 3'(r)) && (cnt[r] != '0);
            if (inc && !dec)
                cnt_next[r] = cnt[r] + CNT_W'(1);
            else if (dec && !inc)
                cnt_next[r] = cnt[r] - CNT_W'(1);
            busy_next[r] = (cnt_next[r] != '0);
            if (cnt_next[r] != '0)
                all_zero_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            halted    <= 1'b0;
            err       <= 1'b0;
            busy_mask <= '0;
            for (int r = 0; r < NUM_REGS; r++)
                cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                cnt[r] <= cnt_next[r];
            busy_mask <= busy_next;
            err       <= err | underflow;
            case (state)
                RUN: begin
                    // The halt itself issues; skip DRAIN when nothing is left outstanding.
                    if (issue && id_halt) begin
                        if (all_zero_next) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end else begin
                            state  <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (all_zero_next) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end
                end
                HALTED: begin
                    halted <= 1'b1;
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule
